// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-adder error-evaluation harness.
package approx_eval_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_W         = 16;
   localparam int unsigned DEF_N_SAMPLES = 1024;
   localparam int unsigned DEF_ACC_W     = 40;
   localparam int unsigned DEF_CNT_W     = 16;

   // Unsigned add clamped to w-bit all-ones; operands must already fit in w bits (w <= 62).
   function automatic logic [63:0] sat_add_u(input logic [63:0] acc,
                                             input logic [63:0] inc,
                                             input int unsigned w);
      logic [63:0] lim;
      logic [63:0] s;
      lim = (64'd1 << w) - 64'd1;
      s   = acc + inc;
      return (s > lim) ? lim : s;
   endfunction

   // Signed add clamped to the w-bit two's-complement range (w <= 62).
   function automatic logic signed [63:0] sat_add_s(input logic signed [63:0] acc,
                                                    input logic signed [63:0] inc,
                                                    input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] s;
      hi = $signed((64'd1 << (w - 1)) - 64'd1);
      lo = -hi - 64'sd1;
      s  = acc + inc;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/approx_adder_err_monitor_if.sv
// Operand/sum beat channel from the stimulus source into the error monitor.
interface approx_adder_err_monitor_if
   import approx_eval_pkg::*;
#(
   parameter int unsigned W = DEF_W
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W:0]   approx_sum;

   modport master (output in_valid, op_a, op_b, approx_sum, input in_ready);
   modport slave  (input in_valid, op_a, op_b, approx_sum, output in_ready);
endinterface

// File: rtl/err_stat_accum.sv
// Second pipeline stage: |error|, first-occurrence max tracking and saturating sums.
module err_stat_accum
   import approx_eval_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned ACC_W = DEF_ACC_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                in_v,
   input  logic signed [W+1:0] diff,
   input  logic [W-1:0]        op_a,
   input  logic [W-1:0]        op_b,
   output logic [CNT_W-1:0]    err_count,
   output logic [W:0]          max_abs_err,
   output logic [ACC_W-1:0]    sum_abs_err,
   output logic [ACC_W-1:0]    sum_signed_err,
   output logic [W-1:0]        worst_a,
   output logic [W-1:0]        worst_b
);

   logic [W:0]       abs_c;
   logic [ACC_W-1:0] sum_abs_c;
   logic [ACC_W-1:0] sum_signed_c;

   // Magnitude of a (W+2)-bit difference always fits in W+1 bits.
   assign abs_c = diff[W+1] ? (W+1)'(-diff) : (W+1)'(diff);

   assign sum_abs_c    = ACC_W'(sat_add_u(64'(sum_abs_err), 64'(abs_c), ACC_W));
   assign sum_signed_c = ACC_W'(sat_add_s(64'($signed(sum_signed_err)), 64'(diff), ACC_W));

   // Stat registers: cleared on window start, updated once per beat leaving S1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count      <= '0;
         max_abs_err    <= '0;
         sum_abs_err    <= '0;
         sum_signed_err <= '0;
         worst_a        <= '0;
         worst_b        <= '0;
      end else if (clear) begin
         err_count      <= '0;
         max_abs_err    <= '0;
         sum_abs_err    <= '0;
         sum_signed_err <= '0;
         worst_a        <= '0;
         worst_b        <= '0;
      end else if (in_v) begin
         if (diff != '0) err_count <= err_count + CNT_W'(1);
         // Strictly greater keeps the earliest beat on ties.
         if (abs_c > max_abs_err) begin
            max_abs_err <= abs_c;
            worst_a     <= op_a;
            worst_b     <= op_b;
         end
         sum_abs_err    <= sum_abs_c;
         sum_signed_err <= sum_signed_c;
      end
   end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Windowed error monitor for an approximate adder: FSM, handshake, beat counter and stage S1.
module approx_adder_err_monitor
   import approx_eval_pkg::*;
#(
   parameter int unsigned W         = DEF_W,
   parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
   parameter int unsigned ACC_W     = DEF_ACC_W,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   approx_adder_err_monitor_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     err_count,
   output logic [W:0]           max_abs_err,
   output logic [ACC_W-1:0]     sum_abs_err,
   output logic [ACC_W-1:0]     sum_signed_err,
   output logic [W-1:0]         worst_a,
   output logic [W-1:0]         worst_b
);

   state_t             state_q, state_d;
   logic               in_ready_q, busy_q, done_q;
   logic               ready_d, busy_d, done_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               accept_c, last_c, enter_run_c;
   logic               s1_v_q;
   logic signed [W+1:0] diff_q;
   logic [W-1:0]       a_q, b_q;
   logic [W:0]         exact_c;
   logic [W+1:0]       diff_c;

   assign bus.in_ready = in_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;

   assign accept_c    = bus.in_valid && in_ready_q;
   assign last_c      = accept_c && (cnt_q == CNT_W'(N_SAMPLES - 1));
   assign enter_run_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   assign exact_c = (W+1)'(bus.op_a) + (W+1)'(bus.op_b);
   assign diff_c  = (W+2)'(exact_c) - (W+2)'(bus.approx_sum);

   // Next state and next registered status outputs.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start)   state_d = ST_RUN;
         ST_RUN:   if (last_c)  state_d = ST_DRAIN;
         ST_DRAIN: if (!s1_v_q) state_d = ST_DONE;
         ST_DONE:  if (start)   state_d = ST_RUN;
         default:               state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_RUN);
      busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d  = (state_d == ST_DONE);
   end

   // FSM state and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Accepted-beat counter and stage S1 (exact sum and signed difference).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         s1_v_q <= 1'b0;
         diff_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         s1_v_q <= accept_c;
         if (enter_run_c)   cnt_q <= '0;
         else if (accept_c) cnt_q <= cnt_q + CNT_W'(1);
         if (accept_c) begin
            diff_q <= diff_c;
            a_q    <= bus.op_a;
            b_q    <= bus.op_b;
         end
      end
   end

   err_stat_accum #(
      .W     (W),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_accum (
      .clk            (clk),
      .rst            (rst),
      .clear          (enter_run_c),
      .in_v           (s1_v_q),
      .diff           (diff_q),
      .op_a           (a_q),
      .op_b           (b_q),
      .err_count      (err_count),
      .max_abs_err    (max_abs_err),
      .sum_abs_err    (sum_abs_err),
      .sum_signed_err (sum_signed_err),
      .worst_a        (worst_a),
      .worst_b        (worst_b)
   );

endmodule
